// File: rtl/axis_bram_dac_player.sv
// Loops a block-RAM waveform out as an AXI4-Stream of signed DAC sample pairs.
// Address register -> 1-cycle BRAM -> 2-entry skid buffer with registered AXIS outputs.
module axis_bram_dac_player #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 16,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_length,
    input  logic [CNTR_WIDTH-1:0]       cfg_cycles,
    input  logic                        start,
    input  logic                        stop,
    output logic                        sts_busy,
    output logic [CNTR_WIDTH-1:0]       sts_loops,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);

    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [CNTR_WIDTH-1:0]      CNT_ONE  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                        state_q;
    logic [BRAM_ADDR_WIDTH-1:0]    addr_q, len_q, addr_d;
    logic [CNTR_WIDTH-1:0]         cycles_q, loops_q, loops_d;
    logic                          rd_pend_q, rd_last_q;
    logic [AXIS_TDATA_WIDTH-1:0]   out_data_q, skid_data_q;
    logic                          out_valid_q, out_last_q;
    logic                          skid_valid_q, skid_last_q;

    logic       pop, push, flush, at_end, final_loop, issue;
    logic [1:0] used;

    always_comb begin
        pop        = out_valid_q && m_axis_tready;
        push       = rd_pend_q;
        flush      = (state_q != IDLE) && stop;
        // Buffer entries plus the read in flight must leave room for one more,
        // counting the slot freed by this cycle's handshake.
        used       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
        at_end     = (addr_q == len_q - ADDR_ONE);
        final_loop = (cycles_q != '0) && ((loops_q + CNT_ONE) == cycles_q);
        issue      = (state_q == RUN) && !stop && (used <= (pop ? 2'd2 : 2'd1));
        addr_d     = at_end ? '0 : addr_q + ADDR_ONE;
        loops_d    = ((cycles_q == '0) && (loops_q == '1)) ? loops_q : loops_q + CNT_ONE;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cycles_q  <= '0;
            loops_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_pend_q <= issue;
            rd_last_q <= issue && at_end;
            case (state_q)
                IDLE: begin
                    if (start && !stop && (cfg_length != '0)) begin
                        state_q  <= RUN;
                        len_q    <= cfg_length;
                        cycles_q <= cfg_cycles;
                        addr_q   <= '0;
                        loops_q  <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        addr_q  <= '0;
                    end else if (issue) begin
                        addr_q <= addr_d;
                        if (at_end) begin
                            loops_q <= loops_d;
                            if (final_loop) state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (stop || (!out_valid_q && !skid_valid_q && !rd_pend_q)) begin
                        state_q <= IDLE;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Skid buffer: the output register refills from the skid entry first so order is kept.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_last_q   <= skid_last_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= push;
                skid_data_q  <= bram_porta_rddata;
                skid_last_q  <= rd_last_q;
            end else begin
                out_valid_q <= push;
                out_last_q  <= push && rd_last_q;
                if (push) out_data_q <= bram_porta_rddata;
            end
        end else if (push) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= bram_porta_rddata;
            skid_last_q  <= rd_last_q;
        end
    end

    assign sts_busy        = (state_q != IDLE);
    assign sts_loops       = loops_q;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = areset;
    assign bram_porta_addr = addr_q;
    assign m_axis_tdata    = out_data_q;
    assign m_axis_tvalid   = out_valid_q;
    assign m_axis_tlast    = out_last_q;

endmodule

// File: tb/tb_axis_bram_dac_player.sv
// Randomized bench for axis_bram_dac_player: a BRAM model feeds the DUT and a
// scoreboard built from the looped waveform checks every presented AXIS word.
module tb_axis_bram_dac_player;

    logic        clk = 1'b0;
    logic        areset, start, stop, tready;
    logic [15:0] cfg_length, cfg_cycles;
    logic        busy, bram_clk, bram_rst, tvalid, tlast;
    logic [15:0] loops, bram_addr;
    logic [31:0] bram_rddata, tdata;

    logic [31:0] mem [0:255];
    logic [32:0] exp_q [$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, hs_cnt = 0, first_hs = 0, last_hs = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bram_rddata <= mem[bram_addr[7:0]];

    axis_bram_dac_player dut (
        .aclk(clk), .areset(areset), .cfg_length(cfg_length), .cfg_cycles(cfg_cycles),
        .start(start), .stop(stop), .sts_busy(busy), .sts_loops(loops),
        .bram_porta_clk(bram_clk), .bram_porta_rst(bram_rst), .bram_porta_addr(bram_addr),
        .bram_porta_rddata(bram_rddata), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Scoreboard: any word shown while tvalid must be the next expected one.
    always @(negedge clk) begin
        if (mon_en && tvalid) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(tvalid), 64'd0);
            end else begin
                check("tdata", 64'(tdata), 64'(exp_q[0][31:0]));
                check("tlast", 64'(tlast), 64'(exp_q[0][32]));
                if (tready) begin
                    $display("txn %0d: data=%08h last=%0b", hs_cnt, tdata, tlast);
                    void'(exp_q.pop_front());
                    if (hs_cnt == 0) first_hs = cyc;
                    last_hs = cyc;
                    hs_cnt++;
                end
            end
        end
    end

    task automatic load_exp(input int len, input int total);
        logic [32:0] e;
        exp_q.delete();
        hs_cnt = 0;
        for (int k = 0; k < total; k++) begin
            e[31:0] = mem[k % len];
            e[32]   = ((k % len) == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int len, input int n);
        @(posedge clk); #1;
        cfg_length = 16'(len);
        cfg_cycles = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic latency_check();
        @(negedge clk); check("lat_busy", 64'(busy), 64'd1); check("lat_e0", 64'(tvalid), 64'd0);
        @(negedge clk); check("lat_e1", 64'(tvalid), 64'd0);
        @(negedge clk); check("lat_e2", 64'(tvalid), 64'd1);
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1;
        cfg_length = '0; cfg_cycles = '0;
        for (int i = 0; i < 256; i++) mem[i] = i;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_loops", 64'(loops), 64'd0);

        // 1: BRAM[i]=i, L=4, N=2
        load_exp(4, 8); mon_en = 1'b1;
        do_start(4, 2);
        latency_check();
        wait_idle(50);
        check("t1_left", 64'(exp_q.size()), 64'd0);
        check("t1_loops", 64'(loops), 64'd2);
        check("t1_contig", 64'(last_hs - first_hs + 1), 64'd8);

        // 2: L=1, N=3, random content
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        load_exp(1, 3);
        do_start(1, 3);
        latency_check();
        wait_idle(50);
        check("t2_left", 64'(exp_q.size()), 64'd0);
        check("t2_loops", 64'(loops), 64'd3);
        check("t2_contig", 64'(last_hs - first_hs + 1), 64'd3);

        // 3/4: L=5, N=0, random backpressure, then stop and restart
        load_exp(5, 400);
        do_start(5, 0);
        repeat (200) begin
            @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
        end
        check("t3_progress", 64'(hs_cnt > 20), 64'd1);
        check("t3_busy", 64'(busy), 64'd1);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        check("t4_stop_tvalid", 64'(tvalid), 64'd0);
        check("t4_stop_busy", 64'(busy), 64'd0);
        tready = 1'b1;
        load_exp(5, 5);
        do_start(5, 1);
        wait_idle(50);
        check("t4_restart_left", 64'(exp_q.size()), 64'd0);
        check("t4_restart_loops", 64'(loops), 64'd1);

        // 5: ignored starts
        exp_q.delete();
        do_start(0, 2);
        repeat (3) @(negedge clk);
        check("t5_len0_busy", 64'(busy), 64'd0);
        check("t5_len0_tvalid", 64'(tvalid), 64'd0);
        @(posedge clk); #1 cfg_length = 16'd3; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("t5_startstop_busy", 64'(busy), 64'd0);
        load_exp(3, 6);
        do_start(3, 2);
        repeat (2) @(posedge clk);
        do_start(7, 1);
        wait_idle(50);
        check("t5_run_left", 64'(exp_q.size()), 64'd0);
        check("t5_run_loops", 64'(loops), 64'd2);

        // 6: reset with the buffer full and tready low
        tready = 1'b0;
        load_exp(6, 50);
        do_start(6, 0);
        repeat (6) @(negedge clk);
        check("t6_full_tvalid", 64'(tvalid), 64'd1);
        mon_en = 1'b0;
        @(posedge clk); #1 areset = 1'b1;
        @(posedge clk); #1 areset = 1'b0;
        @(negedge clk);
        check("t6_tvalid", 64'(tvalid), 64'd0);
        check("t6_tlast", 64'(tlast), 64'd0);
        check("t6_tdata", 64'(tdata), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_loops", 64'(loops), 64'd0);
        check("t6_addr", 64'(bram_addr), 64'd0);
        repeat (3) @(negedge clk);
        check("t6_addr_hold", 64'(bram_addr), 64'd0);
        tready = 1'b1;
        load_exp(6, 6); mon_en = 1'b1;
        do_start(6, 1);
        wait_idle(50);
        check("t6_replay_left", 64'(exp_q.size()), 64'd0);
        check("t6_replay_cnt", 64'(hs_cnt), 64'd6);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
